automata_stream_ctrl: RTL and testbench

- Sequences one input stream of 16-bit characters (two 8-bit symbols per character) into the STE array.
- Clears the array's active-state flops before each stream and gates array advance with char_en.
- Captures every non-zero report vector, tagged with its character offset, into an internal report FIFO.
- Sits between the host byte-stream DMA and the STE array / FF network.

---
 rtl/automata_stream_ctrl.sv | 161 ++++++++++++++++
 tb/tb_automata_stream_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/automata_stream_ctrl.sv
// Stream controller: clears the STE array, feeds it one stream of 16-bit characters
// and queues every non-zero report vector with its character offset.
// Optional build macro RPT_DROP_EN: no FIFO backpressure; overflowing reports are counted.
module automata_stream_ctrl #(
  parameter int NUM_REPORTS = 2,
  parameter int OFFSET_W    = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [OFFSET_W-1:0]             stream_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [15:0]                     in_data,
  output logic [15:0]                     char,
  output logic                            char_en,
  output logic                            array_clear,
  input  logic [NUM_REPORTS-1:0]          report_vec,
  output logic                            rpt_valid,
  input  logic                            rpt_ready,
  output logic [OFFSET_W+NUM_REPORTS-1:0] rpt_data,
  output logic                            busy,
  output logic                            done
`ifdef RPT_DROP_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = OFFSET_W + NUM_REPORTS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] len_q;
  logic [OFFSET_W-1:0] offset_q;
  logic                accept_start;
  logic                last_char;

  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      fifo_count;
  logic                fifo_full, fifo_empty;
  logic                has_report, push, pop;

  assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // The array sees the host character directly; char_en alone decides whether it counts.
  assign char      = in_data;
`ifdef RPT_DROP_EN
  assign in_ready  = (state_q == S_RUN);
`else
  assign in_ready  = (state_q == S_RUN) && !fifo_full;
`endif
  assign char_en   = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign last_char = (offset_q == len_q - OFFSET_W'(1));

  assign has_report = |report_vec;
  assign pop        = rpt_valid && rpt_ready;
`ifdef RPT_DROP_EN
  logic drop;
  // A full FIFO that is popped this cycle still has room for the new entry.
  assign push = char_en && has_report && (!fifo_full || pop);
  assign drop = char_en && has_report && fifo_full && !pop;
`else
  assign push = char_en && has_report;
`endif

  assign rpt_valid = !fifo_empty;
  assign rpt_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    array_clear  = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        array_clear = 1'b1;
        state_d     = (len_q != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        if (char_en && last_char) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      offset_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        len_q    <= stream_len;
        offset_q <= '0;
      end else if (char_en) begin
        offset_q <= offset_q + OFFSET_W'(1);
      end
    end
  end

  // Pointers are exactly log2(depth) wide, so they wrap without explicit compare.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset; the count gates every read, so stale words never escape.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {offset_q, report_vec};
  end

`ifdef RPT_DROP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept_start) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_automata_stream_ctrl.sv
// Randomized bench for automata_stream_ctrl against a queue-based stream model.
// Build with +define+RPT_DROP_EN to exercise the drop-on-overflow variant.
module tb_automata_stream_ctrl;

  localparam int NR      = 2;
  localparam int OW      = 32;
  localparam int DEPTH   = 8;
  localparam int ENTRY_W = OW + NR;
`ifdef RPT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [OW-1:0]      stream_len;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_data;
  logic [15:0]        char;
  logic               char_en;
  logic               array_clear;
  logic [NR-1:0]      report_vec;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [ENTRY_W-1:0] rpt_data;
  logic               busy;
  logic               done;
`ifdef RPT_DROP_EN
  logic [15:0]        drop_count;
`endif

  always #5 clock = ~clock;

  automata_stream_ctrl #(.NUM_REPORTS(NR), .OFFSET_W(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stream_len  (stream_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .char        (char),
    .char_en     (char_en),
    .array_clear (array_clear),
    .report_vec  (report_vec),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_data    (rpt_data),
    .busy        (busy),
`ifdef RPT_DROP_EN
    .done        (done),
    .drop_count  (drop_count)
`else
    .done        (done)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  // Stream model: where we are in the stream, characters still owed, and the report queue.
  typedef enum {M_IDLE, M_CLEAR, M_RUN, M_DRAIN} mphase_t;
  mphase_t            m_phase;
  int                 m_left;
  logic [OW-1:0]      m_off;
  logic [ENTRY_W-1:0] m_q[$];
  int                 m_drops;

  // Observed events, tallied from DUT outputs and compared against scenario constants.
  int                 obs_en, obs_clear, obs_done;
  logic [ENTRY_W-1:0] obs_pops[$];

  int cfg_valid_pct, cfg_ready_pct, cfg_vec_pct;
  logic [NR-1:0] cfg_vec_fixed;

  task automatic model_reset();
    m_phase = M_IDLE;
    m_left  = 0;
    m_off   = '0;
    m_drops = 0;
    m_q.delete();
  endtask

  task automatic clear_obs();
    obs_en    = 0;
    obs_clear = 0;
    obs_done  = 0;
    obs_pops.delete();
  endtask

  task automatic drive();
    in_valid  = ($urandom_range(99) < cfg_valid_pct);
    in_data   = 16'($urandom);
    rpt_ready = ($urandom_range(99) < cfg_ready_pct);
    if (cfg_vec_fixed != '0) report_vec = cfg_vec_fixed;
    else report_vec = ($urandom_range(99) < cfg_vec_pct) ? NR'($urandom_range(1, (1 << NR) - 1)) : '0;
  endtask

  // One clock cycle: compare outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic e_ready, e_en, e_clear, e_busy, e_done, e_valid, e_pop;
    logic [ENTRY_W-1:0] e_data;
    mphase_t p;
    int sz;
    #1;
    p       = m_phase;
    sz      = m_q.size();
    e_ready = (p == M_RUN) && (DROP || sz < DEPTH);
    e_en    = in_valid && e_ready;
    e_clear = (p == M_CLEAR);
    e_busy  = (p != M_IDLE);
    e_done  = (p == M_DRAIN) && (sz == 0);
    e_valid = (sz != 0);
    e_data  = e_valid ? m_q[0] : '0;

    vectors++;
    if ({in_ready, char_en, array_clear, busy, done, rpt_valid} !==
        {e_ready, e_en, e_clear, e_busy, e_done, e_valid}) begin
      miscompares++;
      $display("FAIL ctrl t=%0t rdy/en/clr/busy/done/vld got=%b exp=%b", $time,
               {in_ready, char_en, array_clear, busy, done, rpt_valid},
               {e_ready, e_en, e_clear, e_busy, e_done, e_valid});
    end
    vectors++;
    if (char !== in_data) begin
      miscompares++;
      $display("FAIL char t=%0t got=%h exp=%h", $time, char, in_data);
    end
    if (e_valid) begin
      vectors++;
      if (rpt_data !== e_data) begin
        miscompares++;
        $display("FAIL rpt_data t=%0t got=%h exp=%h", $time, rpt_data, e_data);
      end
    end
`ifdef RPT_DROP_EN
    vectors++;
    if (drop_count !== 16'(m_drops)) begin
      miscompares++;
      $display("FAIL drop_count t=%0t got=%0d exp=%0d", $time, drop_count, m_drops);
    end
`endif

    if (char_en === 1'b1)     obs_en++;
    if (array_clear === 1'b1) obs_clear++;
    if (done === 1'b1)        obs_done++;
    if (rpt_valid === 1'b1 && rpt_ready === 1'b1) obs_pops.push_back(rpt_data);

    e_pop = e_valid && rpt_ready;
    @(posedge clock);
    if (e_pop) m_q.delete(0);
    case (p)
      M_IDLE: if (start) begin
        m_phase = M_CLEAR;
        m_left  = int'(stream_len);
        m_off   = '0;
        m_drops = 0;
      end
      M_CLEAR: m_phase = (m_left != 0) ? M_RUN : M_DRAIN;
      M_RUN: if (e_en) begin
        if (report_vec != '0) begin
          if (m_q.size() < DEPTH) m_q.push_back({m_off, report_vec});
          else if (m_drops < 65535) m_drops++;
        end
        m_off++;
        m_left--;
        if (m_left == 0) m_phase = M_DRAIN;
      end
      M_DRAIN: if (e_done) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    #1;
  endtask

  task automatic begin_stream(input int len);
    drive();
    start      = 1'b1;
    stream_len = OW'(len);
    tick();
    start      = 1'b0;
  endtask

  task automatic run_to_idle(input int limit, input string name);
    int n = 0;
    while (m_phase != M_IDLE && n < limit) begin
      drive();
      tick();
      n++;
    end
    vectors++;
    if (m_phase != M_IDLE) begin
      miscompares++;
      $display("FAIL %s timeout: stream still active after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stream_len = '0; in_valid = 1'b0;
    in_data = '0; report_vec = '0; rpt_ready = 1'b0;
    #2;
    vectors++;
    if ({in_ready, array_clear, char_en, rpt_valid, busy, done} !== 6'b0 || rpt_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%b/%h exp=000000/0",
               {in_ready, array_clear, char_en, rpt_valid, busy, done}, rpt_data);
    end
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [15:0] chars [4];
    chars = '{16'h4141, 16'h4343, 16'h4343, 16'h4141};
    clear_obs();
    cfg_vec_fixed = '0;
    start = 1'b1; stream_len = 4; in_valid = 1'b0; report_vec = '0; rpt_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && m_phase != M_IDLE; n++) begin
      in_valid   = (m_off < 4);
      in_data    = chars[m_off[1:0]];
      report_vec = (m_off == 1) ? 2'b01 : 2'b00;
      rpt_ready  = 1'b1;
      tick();
    end
    vectors++;
    if (obs_clear != 1 || obs_en != 4 || obs_done != 1) begin
      miscompares++;
      $display("FAIL basic_counts clear/en/done got=%0d/%0d/%0d exp=1/4/1", obs_clear, obs_en, obs_done);
    end
    vectors++;
    if (obs_pops.size() != 1 || obs_pops[0] !== {32'd1, 2'b01}) begin
      miscompares++;
      $display("FAIL basic_report got %0d entries (first=%h) exp 1 entry %h",
               obs_pops.size(), (obs_pops.size() > 0) ? obs_pops[0] : '0, {32'd1, 2'b01});
    end
    tick();
  endtask

  task automatic test_zero_len();
    clear_obs();
    cfg_valid_pct = 100; cfg_ready_pct = 100; cfg_vec_pct = 100; cfg_vec_fixed = '0;
    begin_stream(0);
    run_to_idle(20, "zero_len");
    vectors++;
    if (obs_en != 0 || obs_pops.size() != 0 || obs_clear != 1 || obs_done != 1) begin
      miscompares++;
      $display("FAIL zero_len en/pops/clear/done got=%0d/%0d/%0d/%0d exp=0/0/1/1",
               obs_en, obs_pops.size(), obs_clear, obs_done);
    end
  endtask

  task automatic test_backpressure();
    int len;
    len = DROP ? 10 : 12;
    clear_obs();
    cfg_valid_pct = 100; cfg_ready_pct = 0; cfg_vec_fixed = 2'b11;
    begin_stream(len);
    repeat (20) begin
      drive();
      tick();
    end
    vectors++;
    if (obs_en != (DROP ? 10 : DEPTH)) begin
      miscompares++;
      $display("FAIL backpressure_accepted got=%0d exp=%0d", obs_en, DROP ? 10 : DEPTH);
    end
`ifdef RPT_DROP_EN
    vectors++;
    if (drop_count !== 16'd2) begin
      miscompares++;
      $display("FAIL drop_total got=%0d exp=2", drop_count);
    end
`endif
    cfg_ready_pct = 100;
    run_to_idle(100, "backpressure");
    vectors++;
    if (obs_pops.size() != (DROP ? DEPTH : len)) begin
      miscompares++;
      $display("FAIL backpressure_entries got=%0d exp=%0d", obs_pops.size(), DROP ? DEPTH : len);
    end
    for (int i = 0; i < obs_pops.size(); i++) begin
      vectors++;
      if (obs_pops[i] !== {OW'(i), 2'b11}) begin
        miscompares++;
        $display("FAIL backpressure_order[%0d] got=%h exp=%h", i, obs_pops[i], {OW'(i), 2'b11});
      end
    end
    cfg_vec_fixed = '0;
  endtask

  task automatic test_reset_mid_stream();
    int snap_done;
    clear_obs();
    cfg_valid_pct = 100; cfg_ready_pct = 0; cfg_vec_pct = 0; cfg_vec_fixed = '0;
    begin_stream(10);
    for (int n = 0; n < 30 && m_off != 3; n++) begin
      drive();
      report_vec = (m_off == 0 || m_off == 2) ? 2'b01 : 2'b00;
      tick();
    end
    vectors++;
    if (rpt_valid !== 1'b1 || m_q.size() != 2) begin
      miscompares++;
      $display("FAIL midrst_setup rpt_valid=%b entries=%0d exp 1/2", rpt_valid, m_q.size());
    end
    snap_done = obs_done;
    in_valid  = 1'b0;
    reset     = 1'b1;
    #1;
    vectors++;
    if ({rpt_valid, busy, done, in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_async vld/busy/done/rdy got=%b exp=0000", {rpt_valid, busy, done, in_ready});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    vectors++;
    if (obs_done != snap_done) begin
      miscompares++;
      $display("FAIL midrst_done got=%0d exp=%0d", obs_done, snap_done);
    end
    clear_obs();
    cfg_valid_pct = 70; cfg_ready_pct = 60; cfg_vec_pct = 50;
    begin_stream(3);
    run_to_idle(100, "post_reset");
    vectors++;
    if (obs_en != 3 || obs_done != 1 || obs_clear != 1) begin
      miscompares++;
      $display("FAIL post_reset en/done/clear got=%0d/%0d/%0d exp=3/1/1", obs_en, obs_done, obs_clear);
    end
  endtask

  task automatic test_start_ignored();
    clear_obs();
    cfg_valid_pct = 100; cfg_ready_pct = 100; cfg_vec_pct = 50; cfg_vec_fixed = '0;
    begin_stream(5);
    for (int n = 0; n < 20 && m_off != 2; n++) begin
      drive();
      tick();
    end
    drive();
    start = 1'b1; stream_len = 9;
    tick();
    start = 1'b0;
    run_to_idle(100, "start_ignored");
    vectors++;
    if (obs_en != 5 || obs_done != 1 || obs_clear != 1) begin
      miscompares++;
      $display("FAIL start_ignored en/done/clear got=%0d/%0d/%0d exp=5/1/1", obs_en, obs_done, obs_clear);
    end
  endtask

  task automatic test_random_streams();
    int len;
    cfg_vec_fixed = '0;
    for (int s = 0; s < 20; s++) begin
      clear_obs();
      len = $urandom_range(1, 24);
      cfg_valid_pct = $urandom_range(30, 100);
      cfg_ready_pct = $urandom_range(10, 100);
      cfg_vec_pct   = $urandom_range(0, 100);
      begin_stream(len);
      run_to_idle(2000, "random_stream");
      vectors++;
      if (obs_en != len || obs_done != 1) begin
        miscompares++;
        $display("FAIL random_stream[%0d] en/done got=%0d/%0d exp=%0d/1", s, obs_en, obs_done, len);
      end
      repeat ($urandom_range(0, 2)) begin
        drive();
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_valid_pct = 100; cfg_ready_pct = 100; cfg_vec_pct = 0; cfg_vec_fixed = '0;
    model_reset();
    clear_obs();
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_reset_mid_stream();
    test_start_ignored();
    test_random_streams();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
